// File: rtl/ifu_dm_icache.sv
// Direct-mapped instruction cache with a one-stage lookup pipeline.
// Single outstanding line fill; flushes are deferred until any pending response is delivered.
module ifu_dm_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_LINES  = 16,
    parameter int INST_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  CoreReqValid,
    input  logic [ADDR_WIDTH-1:0] CoreReqAddr,
    output logic                  CoreReqReady,
    output logic                  CoreRspValid,
    output logic [INST_WIDTH-1:0] CoreRspInst,
    output logic                  MemReqValid,
    output logic [ADDR_WIDTH-1:0] MemReqAddr,
    input  logic                  MemReqReady,
    input  logic                  MemRspValid,
    input  logic [LINE_WIDTH-1:0] MemRspData,
    input  logic                  FlushReq,
    output logic [31:0]           HitCnt,
    output logic [31:0]           MissCnt
);

    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int WORDS    = LINE_WIDTH / INST_WIDTH;
    localparam int WSEL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT,
        FILL_RSP
    } state_e;

    state_e                  state_q;
    logic                    lk_valid_q;
    logic [ADDR_WIDTH-1:0]   lk_addr_q;
    logic                    flush_pend_q;
    logic [NUM_LINES-1:0]    valid_q;
    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [LINE_WIDTH-1:0]   data_q [NUM_LINES];
    logic                    mem_req_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [31:0]             hit_cnt_q;
    logic [31:0]             miss_cnt_q;

    logic [INDEX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic [WSEL_W-1:0]       lk_wsel;
    logic [LINE_WIDTH-1:0]   lk_line;
    logic                    is_idle;
    logic                    tag_hit;
    logic                    hit;
    logic                    miss_det;
    logic                    flush_any;
    logic                    flush_now;
    logic                    ready;
    logic                    accept;
    logic                    rsp_valid;
    logic                    fill_we;
    logic                    unused_addr_lsb;

    assign lk_idx  = lk_addr_q[OFFSET_W +: INDEX_W];
    assign lk_tag  = lk_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign lk_wsel = lk_addr_q[2 +: WSEL_W];
    assign lk_line = data_q[lk_idx];

    assign unused_addr_lsb = ^lk_addr_q[1:0];

    assign is_idle  = (state_q == IDLE);
    assign tag_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign hit      = is_idle && lk_valid_q && tag_hit;
    assign miss_det = is_idle && lk_valid_q && !tag_hit;

    // A pending or arriving flush blocks new requests so the lookup stage drains first.
    assign flush_any = FlushReq || flush_pend_q;
    assign flush_now = is_idle && !lk_valid_q && flush_any;
    assign ready     = is_idle && !miss_det && !flush_any;
    assign accept    = CoreReqValid && ready;

    assign rsp_valid = hit || (state_q == FILL_RSP);
    assign fill_we   = (state_q == MISS_WAIT) && MemRspValid && !Rst;

    assign CoreReqReady = ready;
    assign CoreRspValid = rsp_valid;
    assign CoreRspInst  = rsp_valid
                        ? lk_line[lk_wsel*INST_WIDTH +: INST_WIDTH]
                        : '0;
    assign MemReqValid  = mem_req_q;
    assign MemReqAddr   = mem_addr_q;
    assign HitCnt       = hit_cnt_q;
    assign MissCnt      = miss_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            lk_valid_q   <= 1'b0;
            lk_addr_q    <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_det) begin
                        state_q    <= MISS_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {lk_tag, lk_idx, {OFFSET_W{1'b0}}};
                    end else begin
                        lk_valid_q <= accept;
                        if (accept) begin
                            lk_addr_q <= CoreReqAddr;
                        end
                    end
                    if (flush_now) begin
                        valid_q <= '0;
                    end
                end
                MISS_REQ: begin
                    if (MemReqReady) begin
                        mem_req_q <= 1'b0;
                        state_q   <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (MemRspValid) begin
                        valid_q[lk_idx] <= 1'b1;
                        state_q         <= FILL_RSP;
                    end
                end
                FILL_RSP: begin
                    lk_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (flush_now) begin
                flush_pend_q <= 1'b0;
            end else if (FlushReq) begin
                flush_pend_q <= 1'b1;
            end

            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_det && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge Clk) begin
        if (fill_we) begin
            tag_q[lk_idx]  <= lk_tag;
            data_q[lk_idx] <= MemRspData;
        end
    end

endmodule

// File: tb/tb_ifu_dm_icache.sv
// Testbench for ifu_dm_icache: directed scenarios plus randomized fetches
// checked against an array-based cache model with a lazily populated memory.
module tb_ifu_dm_icache;

    localparam int NL = 16;

    logic         Clk;
    logic         Rst;
    logic         CoreReqValid;
    logic [31:0]  CoreReqAddr;
    logic         CoreReqReady;
    logic         CoreRspValid;
    logic [31:0]  CoreRspInst;
    logic         MemReqValid;
    logic [31:0]  MemReqAddr;
    logic         MemReqReady;
    logic         MemRspValid;
    logic [127:0] MemRspData;
    logic         FlushReq;
    logic [31:0]  HitCnt;
    logic [31:0]  MissCnt;

    ifu_dm_icache #(
        .ADDR_WIDTH(32),
        .LINE_WIDTH(128),
        .NUM_LINES (NL),
        .INST_WIDTH(32)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .CoreReqValid(CoreReqValid),
        .CoreReqAddr (CoreReqAddr),
        .CoreReqReady(CoreReqReady),
        .CoreRspValid(CoreRspValid),
        .CoreRspInst (CoreRspInst),
        .MemReqValid (MemReqValid),
        .MemReqAddr  (MemReqAddr),
        .MemReqReady (MemReqReady),
        .MemRspValid (MemRspValid),
        .MemRspData  (MemRspData),
        .FlushReq    (FlushReq),
        .HitCnt      (HitCnt),
        .MissCnt     (MissCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    bit           mv [NL];
    logic [31:0]  mline [NL];
    logic [127:0] mem_lines [logic [31:0]];
    int           exp_hits;
    int           exp_misses;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'hF;
    endfunction

    task automatic get_line(input logic [31:0] la, output logic [127:0] d);
        if (!mem_lines.exists(la))
            mem_lines[la] = {$urandom, $urandom, $urandom, $urandom};
        d = mem_lines[la];
    endtask

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    endtask

    task automatic model_access(input logic [31:0] a, output bit h,
                                output logic [31:0] w);
        int idx;
        logic [31:0] la;
        logic [127:0] d;
        idx = int'((a / 16) % NL);
        la = line_of(a);
        h = mv[idx] && (mline[idx] == la);
        if (h) exp_hits++;
        else begin
            exp_misses++;
            mv[idx] = 1'b1;
            mline[idx] = la;
        end
        get_line(la, d);
        w = d[((a % 16) / 4) * 32 +: 32];
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Rst = 1'b1;
        CoreReqValid = 1'b0;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        FlushReq = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    // Single fetch acting as the memory; returns what was observed.
    task automatic fetch(input logic [31:0] a, input int rdyd, input int rspd,
                         input bit fl_wait, output logic [31:0] inst,
                         output int lat, output bit missed,
                         output logic [31:0] maddr, output bit ok,
                         output bit tmo);
        int n, rc, wc;
        bit acc, hs, sent, fdone, done;
        logic [127:0] d;
        get_line(line_of(a), d);
        inst = '0; lat = 0; missed = 0; maddr = '0; ok = 1; tmo = 0;
        acc = 0; hs = 0; sent = 0; fdone = 0; done = 0;
        rc = 0; wc = 0; n = 0;
        while (!acc && n < 20) begin
            @(posedge Clk); #1;
            CoreReqValid = 1'b1;
            CoreReqAddr = a;
            @(negedge Clk);
            acc = CoreReqReady;
            n++;
        end
        n = 0;
        while (acc && !done && n < 80) begin
            @(posedge Clk); #1;
            CoreReqValid = 1'b0;
            MemReqReady = (rc >= rdyd);
            MemRspValid = 1'b0;
            FlushReq = 1'b0;
            if (hs && !sent) begin
                if (wc >= rspd) begin
                    MemRspValid = 1'b1;
                    MemRspData = d;
                    sent = 1;
                end else wc++;
            end
            if (fl_wait && hs && !fdone) begin
                FlushReq = 1'b1;
                fdone = 1;
            end
            @(negedge Clk);
            n++;
            if (MemReqValid) begin
                if (!missed) begin
                    missed = 1;
                    maddr = MemReqAddr;
                end
                if (MemReqAddr !== maddr || CoreReqReady !== 1'b0 ||
                    CoreRspValid !== 1'b0 || hs) ok = 0;
                if (MemReqReady) hs = 1;
                else rc++;
            end
            if (CoreRspValid) begin
                done = 1;
                inst = CoreRspInst;
                lat = n;
            end
        end
        if (!done) tmo = 1;
        @(posedge Clk); #1;
        CoreReqValid = 1'b0;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        FlushReq = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge Clk);
        checks++;
        if (CoreReqReady !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", CoreReqReady);
        end
        checks++;
        if (CoreRspValid !== 1'b0) begin
            errors++; $display("FAIL reset_rspvalid: got %b want 0", CoreRspValid);
        end
        checks++;
        if (MemReqValid !== 1'b0) begin
            errors++; $display("FAIL reset_memreq: got %b want 0", MemReqValid);
        end
        checks++;
        if (MemReqAddr !== 32'h0) begin
            errors++; $display("FAIL reset_memaddr: got %h want 0", MemReqAddr);
        end
        checks++;
        if (CoreRspInst !== 32'h0) begin
            errors++; $display("FAIL reset_inst: got %h want 0", CoreRspInst);
        end
        checks++;
        if (HitCnt !== 32'h0 || MissCnt !== 32'h0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", HitCnt, MissCnt);
        end
    endtask

    task automatic test_cold_fetch();
        logic [31:0] inst, maddr, ew;
        int lat;
        bit missed, ok, tmo, eh;
        do_reset();
        mem_lines[32'h100] = {32'h0C0C0C0C, 32'h0B0B0B0B, 32'hDEADBEEF, 32'h0A0A0A0A};
        model_access(32'h104, eh, ew);
        fetch(32'h104, 0, 0, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || missed !== !eh) begin
            errors++; $display("FAIL cold_miss: missed %b tmo %b want missed 1", missed, tmo);
        end
        checks++;
        if (maddr !== 32'h100) begin
            errors++; $display("FAIL cold_memaddr: got %h want 00000100", maddr);
        end
        checks++;
        if (inst !== 32'hDEADBEEF) begin
            errors++; $display("FAIL cold_inst: got %h want deadbeef", inst);
        end
        checks++;
        if (lat != 4 || !ok) begin
            errors++; $display("FAIL cold_latency: got %0d ok %b want 4 ok 1", lat, ok);
        end
        checks++;
        if (MissCnt !== 32'd1 || HitCnt !== 32'd0) begin
            errors++; $display("FAIL cold_cnt: got %0d/%0d want 0/1", HitCnt, MissCnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ew [4];
        bit eh [4];
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            if (i < 4) begin
                CoreReqValid = 1'b1;
                CoreReqAddr = 32'h100 + 32'(4 * i);
                model_access(CoreReqAddr, eh[i], ew[i]);
            end else CoreReqValid = 1'b0;
            @(negedge Clk);
            if (i < 4) begin
                checks++;
                if (CoreReqReady !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, CoreReqReady);
                end
            end
            if (i > 0) begin
                checks++;
                if (CoreRspValid !== 1'b1 || CoreRspInst !== ew[i-1]) begin
                    errors++;
                    $display("FAIL b2b_rsp[%0d]: got v%b %h want v1 %h",
                             i - 1, CoreRspValid, CoreRspInst, ew[i-1]);
                end
            end
            checks++;
            if (MemReqValid !== 1'b0) begin
                errors++; $display("FAIL b2b_memreq[%0d]: got %b want 0", i, MemReqValid);
            end
        end
        @(posedge Clk); #1;
        checks++;
        if (HitCnt !== 32'd4) begin
            errors++; $display("FAIL b2b_hitcnt: got %0d want 4", HitCnt);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] inst, maddr, ew;
        int lat;
        bit missed, ok, tmo, eh;
        model_access(32'h200, eh, ew);
        fetch(32'h200, 0, 1, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || missed !== 1'b1 || maddr !== 32'h200 || inst !== ew) begin
            errors++;
            $display("FAIL conflict_first: missed %b addr %h inst %h want 1 00000200 %h",
                     missed, maddr, inst, ew);
        end
        model_access(32'h100, eh, ew);
        fetch(32'h100, 1, 0, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || missed !== 1'b1 || inst !== ew) begin
            errors++;
            $display("FAIL conflict_refetch: missed %b inst %h want 1 %h", missed, inst, ew);
        end
        checks++;
        if (MissCnt !== 32'(exp_misses)) begin
            errors++; $display("FAIL conflict_misscnt: got %0d want %0d", MissCnt, exp_misses);
        end
    endtask

    task automatic test_stall();
        logic [31:0] inst, maddr, ew;
        int lat;
        bit missed, ok, tmo, eh;
        model_access(32'h304, eh, ew);
        fetch(32'h304, 5, 2, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || !ok || maddr !== 32'h300) begin
            errors++;
            $display("FAIL stall_stable: ok %b tmo %b addr %h want ok 1 addr 00000300",
                     ok, tmo, maddr);
        end
        checks++;
        if (lat != 11 || inst !== ew) begin
            errors++; $display("FAIL stall_rsp: lat %0d inst %h want 11 %h", lat, inst, ew);
        end
    endtask

    task automatic test_flush_miss();
        logic [31:0] inst, maddr, ew;
        int lat;
        bit missed, ok, tmo, eh;
        model_access(32'h1A8, eh, ew);
        fetch(32'h1A8, 1, 3, 1, inst, lat, missed, maddr, ok, tmo);
        model_clear();
        checks++;
        if (tmo || missed !== 1'b1 || inst !== ew || lat != 8) begin
            errors++;
            $display("FAIL flushmiss_rsp: missed %b inst %h lat %0d want 1 %h 8",
                     missed, inst, lat, ew);
        end
        model_access(32'h1A8, eh, ew);
        fetch(32'h1A8, 0, 0, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || missed !== !eh || inst !== ew) begin
            errors++;
            $display("FAIL flushmiss_refetch: missed %b inst %h want %b %h",
                     missed, inst, !eh, ew);
        end
    endtask

    task automatic test_flush_idle();
        logic [31:0] inst, maddr, ew;
        int lat;
        bit missed, ok, tmo, eh;
        model_access(32'h1AC, eh, ew);
        fetch(32'h1AC, 0, 0, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || missed !== 1'b0 || lat != 1 || inst !== ew) begin
            errors++;
            $display("FAIL flushidle_hit: missed %b lat %0d inst %h want 0 1 %h",
                     missed, lat, inst, ew);
        end
        @(posedge Clk); #1;
        FlushReq = 1'b1;
        CoreReqValid = 1'b1;
        CoreReqAddr = 32'h1AC;
        @(negedge Clk);
        checks++;
        if (CoreReqReady !== 1'b0 || CoreRspValid !== 1'b0) begin
            errors++;
            $display("FAIL flushidle_ready: ready %b rsp %b want 0 0", CoreReqReady, CoreRspValid);
        end
        @(posedge Clk); #1;
        FlushReq = 1'b0;
        CoreReqValid = 1'b0;
        model_clear();
        model_access(32'h1A0, eh, ew);
        fetch(32'h1A0, 0, 0, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || missed !== 1'b1 || inst !== ew) begin
            errors++;
            $display("FAIL flushidle_refetch: missed %b inst %h want 1 %h", missed, inst, ew);
        end
    endtask

    task automatic test_reset_miss();
        logic [31:0] inst, maddr, ew;
        int lat, n;
        bit missed, ok, tmo, eh, seen, rsp_seen;
        model_access(32'h100, eh, ew);
        fetch(32'h100, 0, 0, 0, inst, lat, missed, maddr, ok, tmo);
        @(posedge Clk); #1;
        CoreReqValid = 1'b1;
        CoreReqAddr = 32'h500;
        MemReqReady = 1'b1;
        @(negedge Clk);
        seen = 0;
        n = 0;
        while (!seen && n < 10) begin
            @(posedge Clk); #1;
            CoreReqValid = 1'b0;
            @(negedge Clk);
            seen = MemReqValid;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rstmiss_memreq: got 0 want 1");
        end
        @(posedge Clk); #1;
        Rst = 1'b1;
        MemReqReady = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        MemRspValid = 1'b1;
        MemRspData = {$urandom, $urandom, $urandom, $urandom};
        rsp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (CoreRspValid !== 1'b0 || MemReqValid !== 1'b0) rsp_seen = 1;
            @(posedge Clk); #1;
            MemRspValid = 1'b0;
        end
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        checks++;
        if (rsp_seen) begin
            errors++; $display("FAIL rstmiss_norsp: got activity 1 want 0");
        end
        checks++;
        if (HitCnt !== 32'd0 || MissCnt !== 32'd0) begin
            errors++; $display("FAIL rstmiss_cnt: got %0d/%0d want 0/0", HitCnt, MissCnt);
        end
        model_access(32'h100, eh, ew);
        fetch(32'h100, 0, 0, 0, inst, lat, missed, maddr, ok, tmo);
        checks++;
        if (tmo || missed !== 1'b1 || inst !== ew) begin
            errors++;
            $display("FAIL rstmiss_refetch: missed %b inst %h want 1 %h", missed, inst, ew);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, inst, maddr, ew;
        int lat, rdyd, rspd, elat;
        bit missed, ok, tmo, eh, flw;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge Clk); #1;
                FlushReq = 1'b1;
                @(posedge Clk); #1;
                FlushReq = 1'b0;
                model_clear();
            end
            a = $urandom_range(0, 32'h1FF);
            rdyd = $urandom_range(0, 3);
            rspd = $urandom_range(0, 3);
            flw = ($urandom_range(0, 9) == 0);
            model_access(a, eh, ew);
            fetch(a, rdyd, rspd, flw, inst, lat, missed, maddr, ok, tmo);
            if (flw && !eh) model_clear();
            elat = eh ? 1 : 4 + rdyd + rspd;
            checks++;
            if (tmo || missed !== !eh || inst !== ew || lat != elat || !ok ||
                (!eh && maddr !== line_of(a))) begin
                errors++;
                $display("FAIL rand[%0d] a=%h: miss %b inst %h lat %0d maddr %h ok %b want %b %h %0d %h",
                         it, a, missed, inst, lat, maddr, ok, !eh, ew, elat, line_of(a));
            end
        end
        checks++;
        if (HitCnt !== 32'(exp_hits) || MissCnt !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL rand_cnt: got %0d/%0d want %0d/%0d",
                     HitCnt, MissCnt, exp_hits, exp_misses);
        end
    endtask

    initial begin
        Rst = 1'b1;
        CoreReqValid = 1'b0;
        CoreReqAddr = '0;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        MemRspData = '0;
        FlushReq = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        test_reset();
        test_cold_fetch();
        test_back_to_back();
        test_conflict();
        test_stall();
        test_flush_miss();
        test_flush_idle();
        test_reset_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_dm_icache.md
IFU_DM_ICACHE -- requirements
Module: ifu_dm_icache

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter LINE_WIDTH, default 128, cache line width in bits; power of 2, at least 64.
REQ-003 Parameter NUM_LINES, default 16, number of direct-mapped lines; power of 2, at least 2.
REQ-004 Parameter INST_WIDTH, default 32, instruction word width.
REQ-005 Derived widths: OFFSET_W = log2(LINE_WIDTH/8); INDEX_W = log2(NUM_LINES); TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W.
REQ-006 Clk  in  1  single clock; all state changes on rising edge.
REQ-007 Rst  in  1  synchronous, active-high reset.
REQ-008 CoreReqValid  in  1  fetch request valid.
REQ-009 CoreReqAddr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
REQ-010 CoreReqReady  out  1  cache can accept a request this cycle.
REQ-011 CoreRspValid  out  1  instruction valid, single-cycle pulse.
REQ-012 CoreRspInst  out  INST_WIDTH  fetched instruction.
REQ-013 MemReqValid  out  1  line-fill request.
REQ-014 MemReqAddr  out  ADDR_WIDTH  line-aligned fill address, low OFFSET_W bits zero.
REQ-015 MemReqReady  in  1  memory accepts request.
REQ-016 MemRspValid  in  1  fill data valid.
REQ-017 MemRspData  in  LINE_WIDTH  fill line.
REQ-018 FlushReq  in  1  invalidate-all request, one-cycle pulse.
REQ-019 HitCnt, MissCnt  out  32 each  saturating statistics counters.

Function
REQ-020 Storage: per line one valid bit, a TAG_W tag and a LINE_WIDTH data entry, all in flops. Index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]; tag = upper TAG_W bits.
REQ-021 FSM states: IDLE, MISS_REQ, MISS_WAIT, FILL_RSP.
REQ-022 Acceptance: a request is accepted on CoreReqValid & CoreReqReady; the address is registered into the lookup stage.
REQ-023 CoreReqReady = 1 only in IDLE, when no miss is detected in the lookup stage and no flush is taking effect this cycle.
REQ-024 Hit: when the lookup stage holds an address whose line is valid with a matching tag, CoreRspValid = 1 in the cycle after acceptance. Back-to-back hits sustain one instruction per cycle.
REQ-025 Word select: CoreRspInst = line[w*INST_WIDTH +: INST_WIDTH], w = addr[OFFSET_W-1:2].
REQ-026 Miss: lookup stage misses at cycle N+1 -> CoreRspValid = 0, CoreReqReady = 0, FSM enters MISS_REQ at N+2.
REQ-027 MISS_REQ: MemReqValid = 1 with MemReqAddr stable until MemReqReady; on the handshake, go to MISS_WAIT.
REQ-028 MISS_WAIT: MemReqValid = 0. On MemRspValid, write data, tag and valid = 1 to the indexed line, then go to FILL_RSP.
REQ-029 FILL_RSP: CoreRspValid = 1 with the word selected from the filled line; lookup stage cleared; return to IDLE. Miss latency is 3 cycles plus memory wait.
REQ-030 MemRspValid outside MISS_WAIT is ignored.
REQ-031 Flush in IDLE with an empty lookup stage: all valid bits clear at the next edge. A flush has priority over a simultaneous CoreReqValid: that cycle CoreReqReady = 0.
REQ-032 Flush arriving while a lookup is pending or during a miss: latched, then applied in the first IDLE cycle after the pending response is delivered. The fill in progress completes and its response is delivered before the flush takes effect.
REQ-033 HitCnt increments on each lookup-stage hit; MissCnt increments on each miss detection; both saturate at 32'hFFFF_FFFF.
REQ-034 Refill of a valid line overwrites it; no write-back path exists.

Reset
REQ-035 On Rst = 1, at the next edge: FSM = IDLE; lookup stage empty; all valid bits 0; latched flush 0; counters 0.
REQ-036 Outputs at reset: CoreRspValid = 0, MemReqValid = 0, MemReqAddr = 0, CoreRspInst = 0, CoreReqReady = 1 in the first cycle after Rst deasserts.
REQ-037 Reset mid-miss abandons the fill; a MemRspValid arriving after reset is ignored.
REQ-038 Tag and data contents need not be reset.

Verification
REQ-039 Cold fetch of 0x100 -> MemReqAddr = 0x100; MemRspData word1 = 0xDEADBEEF; fetch of 0x104 delivers 0xDEADBEEF in FILL_RSP; MissCnt = 1.
REQ-040 After REQ-039, back-to-back fetches of 0x100, 0x104, 0x108, 0x10C -> four consecutive CoreRspValid cycles with no MemReqValid; HitCnt = 4.
REQ-041 Conflict: 0x100, then 0x200 with NUM_LINES = 16 (same index, different tag) -> second fetch misses; a refetch of 0x100 misses again.
REQ-042 MemReqReady held low for 5 cycles -> MemReqValid and MemReqAddr stay stable; CoreReqReady = 0 throughout.
REQ-043 FlushReq pulsed during MISS_WAIT -> the fill response is still delivered; the next fetch of the same address misses.
REQ-044 Rst asserted in MISS_WAIT, then MemRspValid pulsed -> no CoreRspValid; the next fetch of 0x100 misses.
